// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, flag bit positions,
// controller states and a small flag-packing helper.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_OR  = 3'b001,
    OP_MUL = 3'b010,
    OP_SLL = 3'b011,
    OP_AND = 3'b100,
    OP_SUB = 3'b101,
    OP_XOR = 3'b110,
    OP_CMP = 3'b111
  } opcode_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  // Place the four condition bits at their architectural positions.
  function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                            input logic s, input logic z);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_S] = s;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit retired per cycle.
// The product register starts as {0, b}; each step conditionally adds the
// multiplicand into the upper half and shifts the whole register right.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             hi_nz
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;

  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH:0]     acc_s;
  logic [2*WIDTH-1:0] step_s;

  // One shift-add step on the current product register.
  always_comb begin
    addend_s = prod_q[0] ? mcand_q : {WIDTH{1'b0}};
    acc_s    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
    step_s   = {acc_s, prod_q[WIDTH-1:1]};
  end

  // Operand capture on start, then WIDTH steps; done pulses once the count hits zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= {WIDTH{1'b0}};
      prod_q  <= {(2*WIDTH){1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      done_q  <= 1'b0;
    end else if (start) begin
      mcand_q <= a;
      prod_q  <= {{WIDTH{1'b0}}, b};
      cnt_q   <= CNT_W'(WIDTH);
      done_q  <= 1'b0;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      prod_q  <= step_s;
      cnt_q   <= cnt_q - CNT_W'(1);
      done_q  <= (cnt_q == CNT_W'(1));
    end else begin
      done_q  <= 1'b0;
    end
  end

  assign busy    = (cnt_q != {CNT_W{1'b0}});
  assign done    = done_q;
  assign prod_lo = prod_q[WIDTH-1:0];
  assign hi_nz   = |prod_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_pipe.sv
// Single-issue ALU with a valid/ready front and back end. Simple ops
// complete in one cycle; MUL is handed to the iterative multiplier and the
// controller waits in MUL until the product is ready.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       inst,
  input  logic [WIDTH-1:0] da,
  input  logic [WIDTH-1:0] db,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags,
  output logic             out_wb
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       flags_q, flags_d;
  logic             wb_q, wb_d;
  logic             valid_q, valid_d;

  opcode_e          op_s;
  logic             accept_s;
  logic             is_mul_s;
  logic             mul_start_s;
  logic             mul_busy_s;
  logic             mul_done_s;
  logic             mul_hi_nz_s;
  logic [WIDTH-1:0] mul_prod_s;

  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     sub_s;
  logic [SHW-1:0]     shamt_s;
  logic [2*WIDTH-1:0] sll_s;
  logic               add_ovf_s;
  logic               sub_ovf_s;
  logic [WIDTH-1:0]   res_s;
  logic               res_c_s;
  logic               res_v_s;
  logic               res_wb_s;
  logic [3:0]         res_flags_s;

  assign op_s     = opcode_e'(inst);
  assign in_ready = (state_q == IDLE) && !mul_busy_s && (!valid_q || out_ready);
  assign accept_s = in_valid && in_ready;
  assign is_mul_s = (op_s == OP_MUL) && (MUL_EN != 0);

  if (MUL_EN != 0) begin : g_mul
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start_s),
      .a       (da),
      .b       (db),
      .busy    (mul_busy_s),
      .done    (mul_done_s),
      .prod_lo (mul_prod_s),
      .hi_nz   (mul_hi_nz_s)
    );
  end else begin : g_no_mul
    assign mul_busy_s  = 1'b0;
    assign mul_done_s  = 1'b0;
    assign mul_prod_s  = {WIDTH{1'b0}};
    assign mul_hi_nz_s = 1'b0;
  end

  // Single-cycle datapath; MUL only reaches here when the multiplier is absent and behaves as ADD.
  always_comb begin
    add_s     = {1'b0, da} + {1'b0, db};
    sub_s     = {1'b0, da} - {1'b0, db};
    shamt_s   = db[SHW-1:0];
    sll_s     = {{WIDTH{1'b0}}, da} << shamt_s;
    add_ovf_s = (da[WIDTH-1] == db[WIDTH-1]) && (add_s[WIDTH-1] != da[WIDTH-1]);
    sub_ovf_s = (da[WIDTH-1] != db[WIDTH-1]) && (sub_s[WIDTH-1] != da[WIDTH-1]);
    res_s     = add_s[WIDTH-1:0];
    res_c_s   = add_s[WIDTH];
    res_v_s   = add_ovf_s;
    res_wb_s  = 1'b1;
    case (op_s)
      OP_ADD, OP_MUL: begin
        res_s   = add_s[WIDTH-1:0];
        res_c_s = add_s[WIDTH];
        res_v_s = add_ovf_s;
      end
      OP_SUB: begin
        res_s   = sub_s[WIDTH-1:0];
        res_c_s = sub_s[WIDTH];
        res_v_s = sub_ovf_s;
      end
      OP_CMP: begin
        res_s    = sub_s[WIDTH-1:0];
        res_c_s  = sub_s[WIDTH];
        res_v_s  = sub_ovf_s;
        res_wb_s = 1'b0;
      end
      OP_AND: begin
        res_s   = da & db;
        res_c_s = 1'b0;
        res_v_s = 1'b0;
      end
      OP_OR: begin
        res_s   = da | db;
        res_c_s = 1'b0;
        res_v_s = 1'b0;
      end
      OP_XOR: begin
        res_s   = da ^ db;
        res_c_s = 1'b0;
        res_v_s = 1'b0;
      end
      OP_SLL: begin
        // The bit just above the result is the last one shifted out; zero for a zero shift.
        res_s   = sll_s[WIDTH-1:0];
        res_c_s = sll_s[WIDTH];
        res_v_s = 1'b0;
      end
      default: begin
        res_s   = add_s[WIDTH-1:0];
        res_c_s = add_s[WIDTH];
        res_v_s = add_ovf_s;
      end
    endcase
    res_flags_s = pack_flags(res_v_s, res_c_s, res_s[WIDTH-1], res_s == {WIDTH{1'b0}});
  end

  // Controller next state and result-register updates.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    flags_d     = flags_q;
    wb_d        = wb_q;
    valid_d     = valid_q;
    mul_start_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s && is_mul_s) begin
          // Acceptance implies any pending result retires now.
          state_d     = MUL;
          mul_start_s = 1'b1;
          valid_d     = 1'b0;
        end else if (accept_s) begin
          out_d   = res_s;
          flags_d = res_flags_s;
          wb_d    = res_wb_s;
          valid_d = 1'b1;
        end else if (out_ready) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      MUL: begin
        if (mul_done_s) begin
          out_d   = mul_prod_s;
          flags_d = pack_flags(1'b0, mul_hi_nz_s, mul_prod_s[WIDTH-1],
                               mul_prod_s == {WIDTH{1'b0}});
          wb_d    = 1'b1;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = MUL;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= {WIDTH{1'b0}};
      flags_q <= 4'b0000;
      wb_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      flags_q <= flags_d;
      wb_q    <= wb_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign flags     = flags_q;
  assign out_wb    = wb_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed scenarios on a 32-bit and an 8-bit instance,
// then randomized traffic with stalls checked against an arithmetic model.
module tb_alu_pipe;

  localparam logic [2:0] T_ADD = 3'd0, T_OR = 3'd1, T_MUL = 3'd2, T_SLL = 3'd3;
  localparam logic [2:0] T_AND = 3'd4, T_SUB = 3'd5, T_XOR = 3'd6, T_CMP = 3'd7;

  typedef struct packed {
    logic        wb;
    logic [3:0]  flags;
    logic [63:0] out;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, out_wb;
  logic [2:0]  inst;
  logic [31:0] da, db, out;
  logic [3:0]  flags;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, out_wb8;
  logic [2:0]  inst8;
  logic [7:0]  da8, db8, out8;
  logic [3:0]  flags8;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  alu_pipe #(.WIDTH(32), .MUL_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .da(da), .db(db), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flags(flags), .out_wb(out_wb)
  );

  alu_pipe #(.WIDTH(8), .MUL_EN(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .inst(inst8), .da(da8), .db(db8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out(out8), .flags(flags8), .out_wb(out_wb8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: results from plain wide arithmetic on w-bit operands.
  function automatic res_t model(input logic [2:0] op, input longint unsigned a,
                                 input longint unsigned b, input int w);
    res_t r;
    longint unsigned mask, msb, full;
    longint sa, sb, ss, lo, hi;
    int sh;
    logic c, v;
    mask = (64'd1 << w) - 64'd1;
    msb  = 64'd1 << (w - 1);
    sa = longint'(a); if ((a & msb) != 0) sa = sa - (longint'(1) << w);
    sb = longint'(b); if ((b & msb) != 0) sb = sb - (longint'(1) << w);
    lo = -(longint'(1) << (w - 1));
    hi = (longint'(1) << (w - 1)) - 1;
    c = 1'b0; v = 1'b0; r.wb = 1'b1; full = 64'd0; ss = 0;
    case (op)
      T_ADD: begin full = a + b; c = (full >> w) != 0; ss = sa + sb; v = (ss > hi) || (ss < lo); end
      T_SUB, T_CMP: begin
        full = a - b; c = (a < b); ss = sa - sb; v = (ss > hi) || (ss < lo);
        r.wb = (op != T_CMP);
      end
      T_AND: full = a & b;
      T_OR:  full = a | b;
      T_XOR: full = a ^ b;
      T_MUL: begin full = a * b; c = (full >> w) != 0; end
      T_SLL: begin
        sh = int'(b % longint'(w));
        full = a << sh;
        c = (sh != 0) && (((a >> (w - sh)) & 64'd1) != 0);
      end
      default: full = 64'd0;
    endcase
    r.out   = full & mask;
    r.flags = {v, c, (r.out & msb) != 0, r.out == 64'd0};
    return r;
  endfunction

  // Offer an op to the 32-bit unit; returns 1 time unit after the accepting edge.
  task automatic send32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    inst = op; da = a; db = b; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) chk("send32_accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    inst8 = op; da8 = a; db8 = b; in_valid8 = 1'b1;
    #1;
    while (!in_ready8 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) chk("send8_accept_timeout", in_ready8, 1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  initial begin
    res_t e;
    res_t exp_q[$];
    int lat, sent, cyc, n;
    logic ir_seen, vseen, acc, ret;
    logic [2:0] op;
    logic [7:0] a8, b8;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inst = 3'd0; da = 32'd0; db = 32'd0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; inst8 = 3'd0; da8 = 8'd0; db8 = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out", out, 0);
    chk("reset_flags", flags, 0);
    chk("reset_out_wb", out_wb, 0);
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // ADD wrap to zero: carry, zero flag, one cycle latency.
    send32(T_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("add_valid", out_valid, 1);
    chk("add_out", out, 32'h0);
    chk("add_flags", flags, 4'b0101);
    chk("add_wb", out_wb, 1);

    // CMP signed overflow, no write-back.
    send32(T_CMP, 32'h8000_0000, 32'h0000_0001);
    chk("cmp_out", out, 32'h7FFF_FFFF);
    chk("cmp_flags", flags, 4'b1000);
    chk("cmp_wb", out_wb, 0);

    // MUL with upper-half product: latency and in_ready low throughout, noisy handshakes.
    inst = T_MUL; da = 32'h0001_0000; db = 32'h0001_0000; in_valid = 1'b1;
    #1;
    chk("mul_in_ready_before", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 0; ir_seen = 1'b0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (k < 30) begin
        in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
        inst = T_ADD; da = $urandom; db = $urandom;
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      #1;
      if (in_ready) ir_seen = 1'b1;
      @(posedge clk); #1;
      if (out_valid) lat = k;
    end
    chk("mul_latency", lat, 33);
    chk("mul_in_ready_low", ir_seen, 0);
    chk("mul_out", out, 32'h0);
    chk("mul_flags", flags, 4'b0101);
    chk("mul_wb", out_wb, 1);

    // Back-to-back single-cycle ops, then a five-cycle stall.
    out_ready = 1'b1;
    inst = T_ADD; da = 32'h1234_5678; db = 32'h1111_1111; in_valid = 1'b1;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("b2b_add", {out_valid, out}, {1'b1, 32'h2345_6789});
    inst = T_XOR; da = 32'hF0F0_F0F0; db = 32'h0FF0_0FF0;
    @(posedge clk); #1;
    chk("b2b_xor", {out_valid, out}, {1'b1, 32'hFF00_FF00});
    inst = T_SLL; da = 32'h1800_0001; db = 32'h0000_0004;
    @(posedge clk); #1;
    chk("b2b_sll", {out_valid, out}, {1'b1, 32'h8000_0010});
    chk("b2b_sll_flags", flags, 4'b0110);
    out_ready = 1'b0; inst = T_ADD; da = 32'd2; db = 32'd2;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_hold", {in_ready, out_valid, out_wb, flags, out},
          {1'b0, 1'b1, 1'b1, 4'b0110, 32'h8000_0010});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("retire_and_load", {out_valid, out}, {1'b1, 32'd4});

    // Reset in the middle of a MUL: immediate clear, no late result.
    inst = T_MUL; da = $urandom | 32'd1; db = $urandom | 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mulrst_out_valid", out_valid, 0);
    chk("mulrst_out", out, 0);
    chk("mulrst_flags", flags, 0);
    chk("mulrst_wb", out_wb, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mulrst_in_ready_after", in_ready, 1);
    vseen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) vseen = 1'b1;
    end
    chk("mulrst_no_result", vseen, 0);
    send32(T_ADD, 32'd2, 32'd3);
    chk("mulrst_add", {out_valid, out}, {1'b1, 32'd5});

    // 8-bit instance: shift carry and short multiply.
    send8(T_SLL, 8'h81, 8'h01);
    chk("w8_sll_out", out8, 8'h02);
    chk("w8_sll_flags", flags8, 4'b0100);
    send8(T_MUL, 8'h10, 8'h10);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (out_valid8) lat = k;
    end
    chk("w8_mul_latency", lat, 9);
    chk("w8_mul_out", out8, 8'h00);
    chk("w8_mul_flags", flags8, 4'b0101);
    for (int k = 0; k < 30; k++) begin
      op = 3'($urandom_range(0, 7));
      a8 = 8'($urandom); b8 = (k % 4 == 0) ? a8 : 8'($urandom);
      send8(op, a8, b8);
      n = 0;
      while (!out_valid8 && n < 20) begin @(posedge clk); #1; n++; end
      e = model(op, 64'(a8), 64'(b8), 8);
      chk("w8_rand", {out_wb8, flags8, out8}, {e.wb, e.flags, e.out[7:0]});
    end

    // Randomized traffic with stalls, scoreboard in acceptance order.
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    sent = 0; cyc = 0;
    while ((sent < 150 || exp_q.size() != 0) && cyc < 20000) begin
      if (!in_valid && sent < 150 && $urandom_range(0, 3) != 0) begin
        op = 3'($urandom_range(0, 7));
        if (op == T_MUL && $urandom_range(0, 2) != 0) op = T_XOR;
        da = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
        case ($urandom_range(0, 3))
          0: db = da;
          1: db = 32'hFFFF_FFFF;
          default: db = $urandom;
        endcase
        inst = op; in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      if (ret) begin
        if (exp_q.size() == 0) begin
          chk("rand_spurious_valid", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rand_result", {out_wb, flags, out}, {e.wb, e.flags, e.out[31:0]});
        end
      end
      if (acc) begin
        exp_q.push_back(model(inst, 64'(da), 64'(db), 32));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) in_valid = 1'b0;
    end
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_sent", sent, 150);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
